// File: rtl/fractal_sync_fifo_rd_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fractal_sync_fifo_rd_if                                           |
// | Brief  : valid/ready element stream from the FIFO read stage downstream.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fractal_sync_fifo_rd_if #(
  parameter type fifo_t = logic
);
  logic  valid;
  logic  ready;
  fifo_t element;

  modport master (output valid, output element, input ready);
  modport slave  (input valid, input element, output ready);
endinterface
`default_nettype wire

// File: rtl/fractal_sync_fifo_rd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fractal_sync_fifo_rd                                              |
// | Brief  : FIFO read stage with a 2-entry skid buffer and flush sequencing.  |
// |          Define FRACTAL_SYNC_FIFO_RD_STATS_EN for transfer/drop counters.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fractal_sync_fifo_rd #(
  parameter type         fifo_t    = logic,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef FRACTAL_SYNC_FIFO_RD_STATS_EN
  output logic [CNT_WIDTH-1:0] xfer_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
`endif
  input  logic                 fifo_empty_i,
  input  fifo_t                fifo_element_i,
  output logic                 fifo_pop_o,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  fractal_sync_fifo_rd_if.master out_if
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e     r_state;
  logic [1:0] r_cnt;
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  fifo_t      r_buf [2];
  logic       r_flush_done;

  logic w_valid;
  logic w_xfer;
  logic w_pop;

  // Pop depends only on FIFO state and our own occupancy, never on ready.
  assign w_valid = (r_state == RUN) && (r_cnt != 2'd0);
  assign w_xfer  = w_valid && out_if.ready;
  assign w_pop   = !fifo_empty_i && ((r_state == FLUSH) || (r_cnt != 2'd2));

  assign fifo_pop_o     = w_pop && !rst_i;
  assign out_if.valid   = w_valid && !rst_i;
  assign out_if.element = r_buf[r_rd_ptr];
  assign flush_done_o   = r_flush_done && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= RUN;
      r_cnt        <= 2'd0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_flush_done <= 1'b0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_pop) begin
            r_buf[r_wr_ptr] <= fifo_element_i;
            r_wr_ptr        <= ~r_wr_ptr;
          end
          if (w_xfer) begin
            r_rd_ptr <= ~r_rd_ptr;
          end
          // A flush overrides the pointer moves above; the transfer itself still happened.
          if (flush_i) begin
            r_state  <= FLUSH;
            r_cnt    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
          end else begin
            r_cnt <= r_cnt + {1'b0, w_pop} - {1'b0, w_xfer};
          end
        end
        FLUSH: begin
          if (fifo_empty_i) begin
            r_state      <= RUN;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef FRACTAL_SYNC_FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] r_xfer_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [1:0]           w_drop_inc;
  logic [CNT_WIDTH:0]   w_drop_sum;

  // Elements discarded this cycle: everything left in the buffer at flush, or a FLUSH pop.
  always_comb begin
    w_drop_inc = 2'd0;
    if (r_state == FLUSH) begin
      w_drop_inc = {1'b0, w_pop};
    end else if (flush_i) begin
      w_drop_inc = r_cnt + {1'b0, w_pop} - {1'b0, w_xfer};
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_WIDTH+1)'(w_drop_inc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_xfer_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_xfer && (r_xfer_cnt != '1)) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
      r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
    end
  end

  assign xfer_cnt_o = r_xfer_cnt;
  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
`default_nettype wire
